// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : opcode/state encodings and constants shared by the alu_pipe block
// Rev 1.0
// ============================================================================
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_MUL  = 4'h2,
        OP_DIV  = 4'h3,
        OP_MOD  = 4'h4,
        OP_AND  = 4'h5,
        OP_NAND = 4'h6,
        OP_OR   = 4'h7,
        OP_NOR  = 4'h8,
        OP_XOR  = 4'h9,
        OP_XNOR = 4'hA,
        OP_NOT  = 4'hB,
        OP_SHL  = 4'hC,
        OP_SHR  = 4'hD,
        OP_GT   = 4'hE,
        OP_LT   = 4'hF
    } alu_op_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        DIV  = 1'b1
    } alu_state_e;

    // Replicated across WIDTH bits to form the divide-by-zero quotient
    localparam logic DBZ_Q_FILL = 1'b1;

    function automatic logic is_divmod(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_divider.sv
`default_nettype none
// ============================================================================
// alu_divider : restoring shift-subtract divider, one quotient bit per cycle
// Rev 1.0
// ============================================================================
module alu_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;

    // quo_q doubles as the dividend shift register: its MSB feeds the partial remainder
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        rem_nx  = shifted[WIDTH-1:0];
        quo_nx  = {quo_q[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            rem_nx = trial[WIDTH-1:0];
            quo_nx = {quo_q[WIDTH-2:0], 1'b1};
        end
    end

    // Outputs expose the post-step values so the parent can load on the final edge
    assign busy      = (cnt_q != '0);
    assign done      = (cnt_q == CNT_W'(1));
    assign quotient  = quo_nx;
    assign remainder = rem_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            cnt_q <= CNT_W'(WIDTH);
        end else if (busy) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// alu_pipe : valid/ready ALU, 16 opcodes, 2*WIDTH result, iterative div/mod.
//            Define ALU_SAT_EN to saturate add/sub to WIDTH bits.
// Rev 1.0
// ============================================================================
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       oper,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] msb,
    output logic [WIDTH-1:0] lsb,
    output logic             zero,
    output logic             dbz
);

    localparam int RW = 2 * WIDTH;

    alu_state_e       state;
    logic             div_is_mod;
    logic             accept;
    logic             div_start;
    logic             div_busy;
    logic             div_done;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_rem;
    logic [RW-1:0]    div_res;

    logic [RW-1:0]    ea;
    logic [RW-1:0]    eb;
    logic [RW-1:0]    sum_full;
    logic [RW-1:0]    diff_full;
    logic [RW-1:0]    res_nx;
    logic             dbz_nx;

    assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign div_start = accept && is_divmod(oper) && (b != '0);

    assign ea        = {{WIDTH{1'b0}}, a};
    assign eb        = {{WIDTH{1'b0}}, b};
    assign sum_full  = ea + eb;
    assign diff_full = ea - eb;
    assign div_res   = {{WIDTH{1'b0}}, (div_is_mod ? div_rem : div_quo)};

    alu_divider #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_divider (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .dividend  (a),
        .divisor   (b),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Single-cycle results; the div/mod entries only matter for the b == 0 case
    always_comb begin
        res_nx = '0;
        dbz_nx = 1'b0;
        case (alu_op_e'(oper))
`ifdef ALU_SAT_EN
            OP_ADD:  res_nx = sum_full[WIDTH] ? {{WIDTH{1'b0}}, {WIDTH{1'b1}}}
                                              : {{WIDTH{1'b0}}, sum_full[WIDTH-1:0]};
            OP_SUB:  res_nx = (a < b) ? '0 : {{WIDTH{1'b0}}, diff_full[WIDTH-1:0]};
`else
            OP_ADD:  res_nx = sum_full;
            OP_SUB:  res_nx = diff_full;
`endif
            OP_MUL:  res_nx = ea * eb;
            OP_DIV: begin
                res_nx = {{WIDTH{1'b0}}, {WIDTH{DBZ_Q_FILL}}};
                dbz_nx = (b == '0);
            end
            OP_MOD: begin
                res_nx = ea;
                dbz_nx = (b == '0);
            end
            OP_AND:  res_nx = {{WIDTH{1'b0}}, a & b};
            OP_NAND: res_nx = {{WIDTH{1'b0}}, ~(a & b)};
            OP_OR:   res_nx = {{WIDTH{1'b0}}, a | b};
            OP_NOR:  res_nx = {{WIDTH{1'b0}}, ~(a | b)};
            OP_XOR:  res_nx = {{WIDTH{1'b0}}, a ^ b};
            OP_XNOR: res_nx = {{WIDTH{1'b0}}, ~(a ^ b)};
            OP_NOT:  res_nx = {{WIDTH{1'b0}}, ~a};
            OP_SHL:  res_nx = ea << 1;
            OP_SHR:  res_nx = ea >> 1;
            OP_GT:   res_nx = {{(RW-1){1'b0}}, (a > b)};
            OP_LT:   res_nx = {{(RW-1){1'b0}}, (a < b)};
            default: res_nx = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            div_is_mod <= 1'b0;
            out_valid  <= 1'b0;
            msb        <= '0;
            lsb        <= '0;
            zero       <= 1'b0;
            dbz        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (div_start) begin
                            state      <= DIV;
                            div_is_mod <= (oper == OP_MOD);
                            out_valid  <= 1'b0;
                        end else begin
                            {msb, lsb} <= res_nx;
                            zero       <= (res_nx == '0);
                            dbz        <= dbz_nx;
                            out_valid  <= 1'b1;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                DIV: begin
                    if (div_done) begin
                        {msb, lsb} <= div_res;
                        zero       <= (div_res == '0);
                        dbz        <= 1'b0;
                        out_valid  <= 1'b1;
                        state      <= IDLE;
                    end else if (!div_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// tb_alu_pipe : directed and random checks of alu_pipe against an arithmetic model
// Rev 1.0
// ============================================================================
module tb_alu_pipe;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   oper;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] msb;
    logic [W-1:0] lsb;
    logic         zero;
    logic         dbz;

    int vectors     = 0;
    int miscompares = 0;
    logic [W-1:0] last_msb;
    logic [W-1:0] last_lsb;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .oper      (oper),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .msb       (msb),
        .lsb       (lsb),
        .zero      (zero),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Result computed from plain integer arithmetic on the operand values
    function automatic longint unsigned model(input logic [3:0] op,
                                              input longint unsigned x,
                                              input longint unsigned y);
        longint unsigned m    = (64'd1 << W) - 64'd1;
        longint unsigned full = 64'd1 << (2 * W);
        longint unsigned r;
        case (op)
`ifdef ALU_SAT_EN
            4'h0: r = (x + y > m) ? m : x + y;
            4'h1: r = (x < y) ? 64'd0 : x - y;
`else
            4'h0: r = x + y;
            4'h1: r = (x + full - y) % full;
`endif
            4'h2: r = x * y;
            4'h3: r = (y == 0) ? m : x / y;
            4'h4: r = (y == 0) ? x : x % y;
            4'h5: r = x & y;
            4'h6: r = m & ~(x & y);
            4'h7: r = x | y;
            4'h8: r = m & ~(x | y);
            4'h9: r = x ^ y;
            4'hA: r = m & ~(x ^ y);
            4'hB: r = m & ~x;
            4'hC: r = x * 2;
            4'hD: r = x / 2;
            4'hE: r = (x > y) ? 64'd1 : 64'd0;
            default: r = (x < y) ? 64'd1 : 64'd0;
        endcase
        return r;
    endfunction

    task automatic do_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        longint unsigned er;
        logic            edbz;
        int              elat;
        int              lat;
        int              busy;
        er   = model(op, longint'(x), longint'(y));
        edbz = (op == 4'h3 || op == 4'h4) && (y == 0);
        elat = ((op == 4'h3 || op == 4'h4) && y != 0) ? W + 1 : 1;
        @(negedge clk);
        in_valid  = 1'b1;
        oper      = op;
        a         = x;
        b         = y;
        out_ready = 1'b1;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        oper     = 4'($urandom);
        lat      = 0;
        busy     = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!in_ready) busy++;
        end while (!out_valid && lat < 50);
        check("latency", 32'(lat), 32'(elat));
        check("busy_cycles", 32'(busy), 32'(elat - 1));
        check("msb", 32'(msb), 32'(er[W +: W]));
        check("lsb", 32'(lsb), 32'(er[0 +: W]));
        check("zero", 32'(zero), 32'(er == 0));
        check("dbz", 32'(dbz), 32'(edbz));
        last_msb = msb;
        last_lsb = lsb;
        @(negedge clk);
        check("drained", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int hold_err;
        int stale;
        logic [3:0]   op;
        logic [W-1:0] x;
        logic [W-1:0] y;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        oper      = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_msb", 32'(msb), 32'd0);
        check("rst_lsb", 32'(lsb), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_dbz", 32'(dbz), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        // Reset in the middle of a division must drop it entirely
        @(negedge clk);
        in_valid = 1'b1; oper = 4'h3; a = 8'd200; b = 8'd7; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_div_busy", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("no_stale_result", 32'(stale), 32'd0);

        do_op(4'h0, 8'hFF, 8'h01);
`ifdef ALU_SAT_EN
        check("add_sat_msb", 32'(last_msb), 32'h00);
        check("add_sat_lsb", 32'(last_lsb), 32'hFF);
`else
        check("add_carry_msb", 32'(last_msb), 32'h01);
        check("add_carry_lsb", 32'(last_lsb), 32'h00);
`endif
        do_op(4'h1, 8'd3, 8'd5);
`ifdef ALU_SAT_EN
        check("sub_sat_lsb", 32'(last_lsb), 32'h00);
`else
        check("sub_neg_msb", 32'(last_msb), 32'hFF);
        check("sub_neg_lsb", 32'(last_lsb), 32'hFE);
`endif
        do_op(4'h3, 8'd200, 8'd7);
        check("div_200_7", 32'(last_lsb), 32'd28);
        do_op(4'h4, 8'd200, 8'd7);
        check("mod_200_7", 32'(last_lsb), 32'd4);
        do_op(4'h3, 8'd50, 8'd0);
        check("div_by_zero", 32'(last_lsb), 32'hFF);
        do_op(4'h4, 8'd50, 8'd0);
        check("mod_by_zero", 32'(last_lsb), 32'd50);
        do_op(4'hC, 8'h81, 8'h00);
        do_op(4'h9, 8'h5A, 8'h5A);
        do_op(4'h4, 8'd6, 8'd3);

        // Back-pressure: mul held, queued xor waits, then drain and accept together
        @(negedge clk);
        in_valid = 1'b1; oper = 4'h2; a = 8'h10; b = 8'h10; out_ready = 1'b0;
        @(posedge clk);
        #1;
        oper = 4'h9; a = 8'hA5; b = 8'h3C;
        hold_err = 0;
        repeat (5) begin
            @(negedge clk);
            if (msb !== 8'h01 || lsb !== 8'h00 || out_valid !== 1'b1 || in_ready !== 1'b0)
                hold_err++;
        end
        check("bp_hold", 32'(hold_err), 32'd0);
        out_ready = 1'b1;
        #1;
        check("bp_ready_on_drain", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("bp_xor_valid", 32'(out_valid), 32'd1);
        check("bp_xor_msb", 32'(msb), 32'h00);
        check("bp_xor_lsb", 32'(lsb), 32'h99);
        check("bp_xor_dbz", 32'(dbz), 32'd0);
        @(negedge clk);
        check("bp_drained", 32'(out_valid), 32'd0);

        repeat (60) begin
            op = 4'($urandom);
            x  = W'($urandom);
            y  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            do_op(op, x, y);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
